// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall generation for the RV32I decode stage.
// A DEPTH-deep shift-register history of in-flight destinations drives youngest-wins forwarding.

`ifndef OPC_LOAD
`define OPC_LOAD   7'b0000011
`endif
`ifndef OPC_STORE
`define OPC_STORE  7'b0100011
`endif
`ifndef OPC_BRANCH
`define OPC_BRANCH 7'b1100011
`endif
`ifndef OPC_OP
`define OPC_OP     7'b0110011
`endif
`ifndef OPC_LUI
`define OPC_LUI    7'b0110111
`endif
`ifndef OPC_AUIPC
`define OPC_AUIPC  7'b0010111
`endif
`ifndef OPC_JAL
`define OPC_JAL    7'b1101111
`endif

module fwd_hazard_ctrl #(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(DEPTH+2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     dec_inst,
  input  logic            dec_valid,
  input  logic            flush,
  output logic [SELW-1:0] a_sel,
  output logic [SELW-1:0] b_sel,
  output logic [SELW-1:0] sd_sel,
  output logic            stall,
  output logic [31:0]     stall_cycles
);

  logic [DEPTH-1:0]      r_vld;
  logic [DEPTH-1:0][4:0] r_rd;
  logic [DEPTH-1:0]      r_ld;
  logic [31:0]           r_stall_cycles;

  logic [6:0] w_opc;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic       w_has_rd, w_use1, w_use2;
  logic       w_unused;

  assign w_opc    = dec_inst[6:0];
  assign w_rd     = dec_inst[11:7];
  assign w_rs1    = dec_inst[19:15];
  assign w_rs2    = dec_inst[24:20];
  assign w_unused = ^{dec_inst[31:25], dec_inst[14:12]};

  assign w_has_rd = dec_valid && (w_opc != `OPC_BRANCH) && (w_opc != `OPC_STORE) && (w_rd != 5'd0);
  assign w_use1   = (w_opc != `OPC_LUI) && (w_opc != `OPC_AUIPC) && (w_opc != `OPC_JAL);
  assign w_use2   = (w_opc == `OPC_OP) || (w_opc == `OPC_BRANCH) || (w_opc == `OPC_STORE);

  // Per-stage comparators; history valid already implies the producer writes a nonzero rd.
  logic [DEPTH-1:0] w_m1, w_m2;
  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign w_m1[k] = r_vld[k] && (r_rd[k] == w_rs1) && (w_rs1 != 5'd0) && w_use1;
    assign w_m2[k] = r_vld[k] && (r_rd[k] == w_rs2) && (w_rs2 != 5'd0) && w_use2;
  end

  logic            w_hit1, w_hit2, w_ld1, w_ld2;
  logic [SELW-1:0] w_k1, w_k2;

  // Scan oldest to youngest so the lowest matching stage overwrites and wins.
  always_comb begin
    w_hit1 = 1'b0; w_k1 = '0; w_ld1 = 1'b0;
    w_hit2 = 1'b0; w_k2 = '0; w_ld2 = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (w_m1[k]) begin
        w_hit1 = 1'b1;
        w_k1   = SELW'(k);
        w_ld1  = r_ld[k] && (k < LOAD_LAT);
      end
      if (w_m2[k]) begin
        w_hit2 = 1'b1;
        w_k2   = SELW'(k);
        w_ld2  = r_ld[k] && (k < LOAD_LAT);
      end
    end
  end

  always_comb begin
    a_sel = '0;
    if ((w_opc == `OPC_AUIPC) || (w_opc == `OPC_JAL) || (w_opc == `OPC_BRANCH))
      a_sel = SELW'(1);
    else if (w_hit1)
      a_sel = w_k1 + SELW'(2);

    b_sel = SELW'(1);
    if (w_opc == `OPC_OP)
      b_sel = w_hit2 ? (w_k2 + SELW'(2)) : '0;

    sd_sel = '0;
    if ((w_opc == `OPC_STORE) && w_hit2)
      sd_sel = w_k2 + SELW'(2);
  end

  assign stall        = dec_valid && (w_ld1 || w_ld2);
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld          <= '0;
      r_rd           <= '0;
      r_ld           <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (stall)
        r_stall_cycles <= r_stall_cycles + 32'd1;
      for (int k = DEPTH-1; k >= 1; k--) begin
        r_rd[k] <= r_rd[k-1];
        r_ld[k] <= r_ld[k-1];
      end
      r_rd[0] <= w_rd;
      r_ld[0] <= (w_opc == `OPC_LOAD);
      if (flush) begin
        r_vld <= '0;
      end else begin
        for (int k = DEPTH-1; k >= 1; k--)
          r_vld[k] <= r_vld[k-1];
        // A stalled decode must not enter the pipe; a bubble goes in its place.
        r_vld[0] <= stall ? 1'b0 : w_has_rd;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed vector bench: DEPTH=2/LOAD_LAT=1 table plus DEPTH=4/LOAD_LAT=3 stall/reset sequences.

module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2, LOAD_LAT=1 instance
  logic        rst0, vld0, fl0;
  logic [31:0] inst0;
  logic [1:0]  a0, b0, sd0;
  logic        st0;
  logic [31:0] cyc0;

  fwd_hazard_ctrl #(.DEPTH(2), .LOAD_LAT(1)) u0 (
    .clk(clk), .rst(rst0), .dec_inst(inst0), .dec_valid(vld0), .flush(fl0),
    .a_sel(a0), .b_sel(b0), .sd_sel(sd0), .stall(st0), .stall_cycles(cyc0));

  // DEPTH=4, LOAD_LAT=3 instance
  logic        rst1, vld1, fl1;
  logic [31:0] inst1;
  logic [2:0]  a1, b1, sd1;
  logic        st1;
  logic [31:0] cyc1;

  fwd_hazard_ctrl #(.DEPTH(4), .LOAD_LAT(3)) u1 (
    .clk(clk), .rst(rst1), .dec_inst(inst1), .dec_valid(vld1), .flush(fl1),
    .a_sel(a1), .b_sel(b1), .sd_sel(sd1), .stall(st1), .stall_cycles(cyc1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1);
    return {12'h000, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    logic [11:0] i;
    i = 12'(imm);
    return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'b0100011};
  endfunction
  // rdf puts arbitrary bits in the rd field position (offset bits for a branch)
  function automatic logic [31:0] beq(input int rs1, input int rs2, input int rdf);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rdf), 7'b1100011};
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic        vld;
    logic        fl;
    logic [1:0]  a, b, sd;
    logic        st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] inst, input logic vld, input logic fl,
                              input int a, input int b, input int sd, input logic st);
    vec_t v;
    v.inst = inst; v.vld = vld; v.fl = fl;
    v.a = 2'(a); v.b = 2'(b); v.sd = 2'(sd); v.st = st;
    return v;
  endfunction

  initial begin
    rst0 = 1'b1; vld0 = 1'b0; fl0 = 1'b0; inst0 = '0;
    rst1 = 1'b1; vld1 = 1'b0; fl1 = 1'b0; inst1 = '0;

    //               inst                     vld fl  a  b  sd st
    tbl.push_back(mk(addi(5,0,1),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(add(6,5,5),              1, 0, 2, 2, 0, 0)); // back-to-back
    tbl.push_back(mk(32'h0,                   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(addi(5,0,1),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(32'h0,                   0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(add(6,5,5),              1, 0, 3, 3, 0, 0)); // one bubble
    tbl.push_back(mk(addi(5,0,1),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(addi(5,0,2),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(add(7,5,5),              1, 0, 2, 2, 0, 0)); // youngest wins
    tbl.push_back(mk(lw(8,1),                 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(add(9,8,0),              1, 0, 2, 0, 0, 1)); // load-use
    tbl.push_back(mk(add(9,8,0),              1, 0, 3, 0, 0, 0));
    tbl.push_back(mk(addi(0,0,5),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(sw(3,2,3),               1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(beq(3,3,3),              1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(add(4,0,3),              1, 0, 0, 0, 0, 0)); // no fwd from non-writers
    tbl.push_back(mk(addi(3,0,7),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(sw(3,2,4),               1, 0, 0, 1, 2, 0)); // store data fwd
    tbl.push_back(mk(addi(3,0,8),             1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(beq(3,3,0),              1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(lw(8,1),                 1, 1, 0, 1, 0, 0)); // flush kills the load
    tbl.push_back(mk(add(9,8,0),              1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(lw(8,1),                 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(add(9,8,0),              1, 1, 2, 0, 0, 1)); // flush + stall
    tbl.push_back(mk(add(9,8,0),              1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(lw(8,1),                 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(sw(8,2,0),               1, 0, 0, 1, 2, 1)); // store-data load-use
    tbl.push_back(mk(sw(8,2,0),               1, 0, 0, 1, 3, 0));
    tbl.push_back(mk(lw(8,1),                 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(add(9,8,0),              0, 0, 2, 0, 0, 0)); // bubble never stalls
    tbl.push_back(mk({12'h000, 5'd8, 3'b000, 5'd10, 7'b0110111}, 1, 0, 0, 1, 0, 0)); // lui ignores rs1 field

    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0; rst1 = 1'b0;
    #3;
    chk("reset a_sel", 32'(a0), 0);
    chk("reset b_sel", 32'(b0), 1);
    chk("reset sd_sel", 32'(sd0), 0);
    chk("reset stall", 32'(st0), 0);
    chk("reset stall_cycles", cyc0, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      inst0 = tbl[i].inst; vld0 = tbl[i].vld; fl0 = tbl[i].fl;
      #3;
      chk($sformatf("vec%0d a_sel", i), 32'(a0), 32'(tbl[i].a));
      chk($sformatf("vec%0d b_sel", i), 32'(b0), 32'(tbl[i].b));
      chk($sformatf("vec%0d sd_sel", i), 32'(sd0), 32'(tbl[i].sd));
      chk($sformatf("vec%0d stall", i), 32'(st0), 32'(tbl[i].st));
      @(posedge clk); #1;
    end
    inst0 = '0; vld0 = 1'b0; fl0 = 1'b0;
    #3 chk("d2 stall_cycles", cyc0, 3);

    // DEPTH=4, LOAD_LAT=3: full 3-cycle load-use stall, then forward from stage 3
    @(posedge clk); #1;
    inst1 = lw(8,1); vld1 = 1'b1;
    @(posedge clk); #1;
    inst1 = add(9,8,0);
    for (int c = 0; c < 3; c++) begin
      #3;
      chk($sformatf("d4 stall c%0d", c), 32'(st1), 1);
      chk($sformatf("d4 a_sel c%0d", c), 32'(a1), 32'(2 + c));
      @(posedge clk); #1;
    end
    #3;
    chk("d4 stall end", 32'(st1), 0);
    chk("d4 a_sel end", 32'(a1), 5);
    chk("d4 stall_cycles", cyc1, 3);
    @(posedge clk); #1;

    // reset in the middle of a stall
    inst1 = lw(8,1);
    @(posedge clk); #1;
    inst1 = add(9,8,0);
    #3 chk("d4 mid stall", 32'(st1), 1);
    @(posedge clk); #1;
    rst1 = 1'b1;
    #3 chk("d4 stall at rst", 32'(st1), 1);
    @(posedge clk); #1;
    rst1 = 1'b0;
    #3;
    chk("d4 stall after rst", 32'(st1), 0);
    chk("d4 a_sel after rst", 32'(a1), 0);
    chk("d4 cycles after rst", cyc1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
